// File: rtl/ofm_writeback.sv
`timescale 1ns / 1ps
// ofm_writeback
// ---------------------------------------------------------------------------
// Packs a stream of 16-bit neuron sums into 64-bit output-buffer words,
// four lanes per word with lane0 in the top 16 bits. There is an optional
// ReLU clamp. Each output plane starts on a fresh word. A plane whose
// neuron count is not a multiple of four ends with a partial word. That
// word has zeroed lanes and cleared byte enables for the unused lanes.
//
// Handshake: sum_valid is a valid-only strobe (there is no ready). A sum is
// consumed on every rising edge where the FSM is in PACK, sum_valid=1 and
// layer_start=0. Sums presented in any other cycle are dropped.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous, active-high reset
//   layer_start  one-cycle pulse that arms (or re-arms) a layer
//   relu_en      ReLU select, latched on layer_start
//   sum_in       signed neuron sum
//   sum_valid    sum_in valid this cycle
//   wr_en        output-buffer write strobe (registered)
//   wr_addr      output-buffer word address (registered)
//   wr_data      packed word, lane0 [63:48] .. lane3 [15:0] (registered)
//   wr_be        byte enables, two bits per lane, [7:6] = lane0 (registered)
//   busy         a layer is in progress
//   plane_done   pulse with the final write of each plane
//   layer_done   pulse one cycle after the final write of the layer
//   err_unexp    sticky: sum_valid seen while not busy
//   dbg_state    current FSM state (0 IDLE, 1 PACK, 2 DONE)
// ---------------------------------------------------------------------------
module ofm_writeback #(
    parameter int PLANE_NEURONS   = 196,
    parameter int NUM_PLANES      = 8,
    parameter int WORDS_PER_PLANE = (PLANE_NEURONS + 3) / 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        layer_start,
    input  logic        relu_en,
    input  logic [15:0] sum_in,
    input  logic        sum_valid,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [63:0] wr_data,
    output logic [7:0]  wr_be,
    output logic        busy,
    output logic        plane_done,
    output logic        layer_done,
    output logic        err_unexp,
    output logic [1:0]  dbg_state
);

    localparam int NC_W = (PLANE_NEURONS > 1) ? $clog2(PLANE_NEURONS) : 1;
    localparam int PL_W = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;
    localparam logic [NC_W-1:0] LAST_NEURON  = NC_W'(PLANE_NEURONS - 1);
    localparam logic [PL_W-1:0] LAST_PLANE   = PL_W'(NUM_PLANES - 1);
    localparam logic [15:0]     PLANE_STRIDE = 16'(WORDS_PER_PLANE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PACK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            relu_q, relu_d;
    logic [1:0]      lane_q, lane_d;
    logic [NC_W-1:0] neuron_q, neuron_d;
    logic [PL_W-1:0] plane_q, plane_d;
    logic [15:0]     word_q, word_d;
    logic [15:0]     base_q, base_d;
    logic [63:0]     pack_q, pack_d;
    logic            wr_en_q, wr_en_d;
    logic [15:0]     wr_addr_q, wr_addr_d;
    logic [63:0]     wr_data_q, wr_data_d;
    logic [7:0]      wr_be_q, wr_be_d;
    logic            busy_q, busy_d;
    logic            plane_done_q, plane_done_d;
    logic            layer_done_q, layer_done_d;
    logic            err_q, err_d;

    logic [15:0] lane_val;
    logic [63:0] word_full;
    logic [7:0]  be_fill;

    always_comb begin
        state_d      = state_q;
        relu_d       = relu_q;
        lane_d       = lane_q;
        neuron_d     = neuron_q;
        plane_d      = plane_q;
        word_d       = word_q;
        base_d       = base_q;
        pack_d       = pack_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_be_d      = wr_be_q;
        busy_d       = busy_q;
        plane_done_d = 1'b0;
        layer_done_d = 1'b0;
        err_d        = err_q;

        lane_val  = (relu_q && sum_in[15]) ? 16'h0000 : sum_in;

        // Current word with the incoming sum merged into the active lane.
        // Lanes above the active one are still zero because pack_q is
        // cleared after every emitted word.
        word_full = pack_q;
        be_fill   = 8'hFF;
        case (lane_q)
            2'd0:    begin word_full[63:48] = lane_val; be_fill = 8'hC0; end
            2'd1:    begin word_full[47:32] = lane_val; be_fill = 8'hF0; end
            2'd2:    begin word_full[31:16] = lane_val; be_fill = 8'hFC; end
            default: begin word_full[15:0]  = lane_val; be_fill = 8'hFF; end
        endcase

        // A start pulse clears the flag, unless it coincides with a stray sum.
        if (layer_start) begin
            err_d = sum_valid && !busy_q;
        end else if (sum_valid && !busy_q) begin
            err_d = 1'b1;
        end

        if (layer_start) begin
            // Fresh start or abort: any partial word is dropped unwritten.
            state_d  = S_PACK;
            relu_d   = relu_en;
            lane_d   = 2'd0;
            neuron_d = '0;
            plane_d  = '0;
            word_d   = 16'd0;
            base_d   = 16'd0;
            pack_d   = 64'd0;
            busy_d   = 1'b1;
            // The layer that just finished still reports completion.
            layer_done_d = (state_q == S_DONE);
        end else begin
            case (state_q)
                S_IDLE: begin
                end
                S_PACK: begin
                    if (sum_valid) begin
                        pack_d   = word_full;
                        lane_d   = lane_q + 2'd1;
                        neuron_d = neuron_q + 1'b1;
                        if (lane_q == 2'd3 || neuron_q == LAST_NEURON) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = base_q + word_q;
                            wr_data_d = word_full;
                            wr_be_d   = be_fill;
                            pack_d    = 64'd0;
                            lane_d    = 2'd0;
                            word_d    = word_q + 16'd1;
                            if (neuron_q == LAST_NEURON) begin
                                plane_done_d = 1'b1;
                                neuron_d     = '0;
                                word_d       = 16'd0;
                                base_d       = base_q + PLANE_STRIDE;
                                plane_d      = plane_q + 1'b1;
                                if (plane_q == LAST_PLANE) begin
                                    state_d = S_DONE;
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_d      = S_IDLE;
                    busy_d       = 1'b0;
                    layer_done_d = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            relu_q       <= 1'b0;
            lane_q       <= 2'd0;
            neuron_q     <= '0;
            plane_q      <= '0;
            word_q       <= 16'd0;
            base_q       <= 16'd0;
            pack_q       <= 64'd0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 16'd0;
            wr_data_q    <= 64'd0;
            wr_be_q      <= 8'd0;
            busy_q       <= 1'b0;
            plane_done_q <= 1'b0;
            layer_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            relu_q       <= relu_d;
            lane_q       <= lane_d;
            neuron_q     <= neuron_d;
            plane_q      <= plane_d;
            word_q       <= word_d;
            base_q       <= base_d;
            pack_q       <= pack_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_be_q      <= wr_be_d;
            busy_q       <= busy_d;
            plane_done_q <= plane_done_d;
            layer_done_q <= layer_done_d;
            err_q        <= err_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_be      = wr_be_q;
    assign busy       = busy_q;
    assign plane_done = plane_done_q;
    assign layer_done = layer_done_q;
    assign err_unexp  = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ofm_writeback.sv
`timescale 1ns / 1ps
module tb_ofm_writeback;

    localparam int W = 90;  // {inst, plane_done, addr[15:0], data[63:0], be[7:0]}

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic chk_on = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // index 0: PLANE_NEURONS=8, NUM_PLANES=2; index 1: PLANE_NEURONS=5, NUM_PLANES=1
    logic        ls[2];
    logic        re[2];
    logic        sv[2];
    logic [15:0] si[2];
    logic        o_wr_en[2];
    logic [15:0] o_addr[2];
    logic [63:0] o_data[2];
    logic [7:0]  o_be[2];
    logic        o_busy[2];
    logic        o_pd[2];
    logic        o_ld[2];
    logic        o_err[2];
    logic [1:0]  o_st[2];

    logic [W-1:0] exp_q[$];
    logic [W-1:0] log_q[$];
    int           ld_cnt[2];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- DUTs ----------------
    ofm_writeback #(.PLANE_NEURONS(8), .NUM_PLANES(2)) u_dut_a (
        .clk(clk), .rst(rst), .layer_start(ls[0]), .relu_en(re[0]),
        .sum_in(si[0]), .sum_valid(sv[0]), .wr_en(o_wr_en[0]), .wr_addr(o_addr[0]),
        .wr_data(o_data[0]), .wr_be(o_be[0]), .busy(o_busy[0]), .plane_done(o_pd[0]),
        .layer_done(o_ld[0]), .err_unexp(o_err[0]), .dbg_state(o_st[0])
    );

    ofm_writeback #(.PLANE_NEURONS(5), .NUM_PLANES(1)) u_dut_b (
        .clk(clk), .rst(rst), .layer_start(ls[1]), .relu_en(re[1]),
        .sum_in(si[1]), .sum_valid(sv[1]), .wr_en(o_wr_en[1]), .wr_addr(o_addr[1]),
        .wr_data(o_data[1]), .wr_be(o_be[1]), .busy(o_busy[1]), .plane_done(o_pd[1]),
        .layer_done(o_ld[1]), .err_unexp(o_err[1]), .dbg_state(o_st[1])
    );

    // ---------------- behavioural model ----------------
    // Works on whole transactions: a list of lanes collected so far, and
    // integer neuron/word/plane counts. It produces the outputs expected
    // after each clock edge.
    logic        e_wr_en[2];
    logic [15:0] e_addr[2];
    logic [63:0] e_data[2];
    logic [7:0]  e_be[2];
    logic        e_pd[2];
    logic        e_ld[2];
    logic        e_busy[2];
    logic        e_err[2];
    logic        m_active[2];
    logic        m_done[2];
    logic        m_relu[2];
    logic        m_err[2];
    int          m_cnt[2];
    int          m_neur[2];
    int          m_word[2];
    int          m_plane[2];
    logic [15:0] m_lane[2][4];

    function automatic int pn_of(input int i);
        return (i == 0) ? 8 : 5;
    endfunction

    function automatic int np_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic model_reset(input int i);
        e_wr_en[i] = 0; e_addr[i] = 0; e_data[i] = 0; e_be[i] = 0;
        e_pd[i] = 0; e_ld[i] = 0; e_busy[i] = 0; e_err[i] = 0;
        m_active[i] = 0; m_done[i] = 0; m_relu[i] = 0; m_err[i] = 0;
        m_cnt[i] = 0; m_neur[i] = 0; m_word[i] = 0; m_plane[i] = 0;
        for (int l = 0; l < 4; l++) m_lane[i][l] = 16'h0;
    endtask

    task automatic model_accept(input int i, input logic [15:0] v);
        logic [63:0] word;
        logic [7:0]  be;
        m_lane[i][m_cnt[i]] = (m_relu[i] && v[15]) ? 16'h0000 : v;
        m_cnt[i]++;
        m_neur[i]++;
        if (m_cnt[i] == 4 || m_neur[i] == pn_of(i)) begin
            word = 64'h0;
            be   = 8'h00;
            for (int l = 0; l < 4; l++) begin
                if (l < m_cnt[i]) begin
                    word[63 - 16*l -: 16] = m_lane[i][l];
                    be[7 - 2*l -: 2]      = 2'b11;
                end
            end
            e_wr_en[i] = 1;
            e_addr[i]  = 16'(m_plane[i] * ((pn_of(i) + 3) / 4) + m_word[i]);
            e_data[i]  = word;
            e_be[i]    = be;
            m_word[i]++;
            m_cnt[i] = 0;
            if (m_neur[i] == pn_of(i)) begin
                e_pd[i]    = 1;
                m_neur[i]  = 0;
                m_word[i]  = 0;
                m_plane[i]++;
                if (m_plane[i] == np_of(i)) begin
                    m_active[i] = 0;
                    m_done[i]   = 1;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) model_reset(i);
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    model_reset(i);
                end else begin
                    e_wr_en[i] = 0;
                    e_pd[i]    = 0;
                    e_ld[i]    = m_done[i];
                    m_done[i]  = 0;
                    if (ls[i]) begin
                        m_err[i]    = sv[i] && !e_busy[i];
                        m_relu[i]   = re[i];
                        m_active[i] = 1;
                        m_cnt[i] = 0; m_neur[i] = 0; m_word[i] = 0; m_plane[i] = 0;
                    end else if (sv[i]) begin
                        if (m_active[i]) model_accept(i, si[i]);
                        else if (!e_busy[i]) m_err[i] = 1;
                    end
                    e_busy[i] = m_active[i] || m_done[i];
                    e_err[i]  = m_err[i];
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int idx, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic inst, input logic pd, input logic [15:0] a,
                                        input logic [63:0] d, input logic [7:0] be);
        return {inst, pd, a, d, be};
    endfunction

    task automatic check_log(input string name);
        int n;
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        check({name, "_count"}, 0, 128'(log_q.size()), 128'(exp_q.size()));
        for (int k = 0; k < n; k++) check(name, k, 128'(log_q[k]), 128'(exp_q[k]));
        log_q.delete();
        exp_q.delete();
    endtask

    // Per-cycle compare against the model, plus a log of actual writes.
    initial begin
        ld_cnt[0] = 0;
        ld_cnt[1] = 0;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                for (int i = 0; i < 2; i++) begin
                    check("ctl", i, {o_wr_en[i], o_pd[i], o_ld[i], o_busy[i], o_err[i]},
                          {e_wr_en[i], e_pd[i], e_ld[i], e_busy[i], e_err[i]});
                    if (e_wr_en[i])
                        check("write", i, {o_addr[i], o_data[i], o_be[i]},
                              {e_addr[i], e_data[i], e_be[i]});
                    if (o_wr_en[i]) log_q.push_back(mk(1'(i), o_pd[i], o_addr[i], o_data[i], o_be[i]));
                    if (o_ld[i]) ld_cnt[i]++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_layer(input int i, input logic relu);
        ls[i] = 1'b1;
        re[i] = relu;
        @(negedge clk);
        ls[i] = 1'b0;
        re[i] = 1'b0;
    endtask

    task automatic send(input int i, input logic [15:0] v, input int gap);
        sv[i] = 1'b1;
        si[i] = v;
        @(negedge clk);
        sv[i] = 1'b0;
        si[i] = 16'hDEAD;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(input int i, input int budget);
        int n;
        n = 0;
        while (o_busy[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", i, 128'(o_busy[i]), 128'(0));
        @(negedge clk);
    endtask

    task automatic push_a_layer();
        exp_q.push_back(mk(0, 0, 16'd0, 64'h0001_0002_0003_0004, 8'hFF));
        exp_q.push_back(mk(0, 1, 16'd1, 64'h0005_0006_0007_0008, 8'hFF));
        exp_q.push_back(mk(0, 0, 16'd2, 64'h0009_000A_000B_000C, 8'hFF));
        exp_q.push_back(mk(0, 1, 16'd3, 64'h000D_000E_000F_0010, 8'hFF));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ld0;
        for (int i = 0; i < 2; i++) begin
            ls[i] = 0; re[i] = 0; sv[i] = 0; si[i] = 16'h0;
        end
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        for (int i = 0; i < 2; i++)
            check("reset_outs", i, {o_wr_en[i], o_addr[i], o_data[i], o_be[i], o_busy[i],
                                    o_pd[i], o_ld[i], o_err[i], o_st[i]}, 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // Two planes of eight, back to back
        start_layer(0, 1'b0);
        for (int v = 1; v <= 16; v++) send(0, 16'(v), 0);
        wait_idle(0, 20);
        push_a_layer();
        check_log("b2b");

        // Same stream, one sum every third cycle
        start_layer(0, 1'b0);
        for (int v = 1; v <= 16; v++) send(0, 16'(v), 2);
        wait_idle(0, 20);
        push_a_layer();
        check_log("gapped");
        check("ld_count_two_layers", 0, 128'(ld_cnt[0]), 128'(2));

        // Five-neuron plane ends with a one-lane partial word
        start_layer(1, 1'b0);
        for (int v = 1; v <= 5; v++) send(1, 16'(v), 0);
        wait_idle(1, 20);
        exp_q.push_back(mk(1, 0, 16'd0, 64'h0001_0002_0003_0004, 8'hFF));
        exp_q.push_back(mk(1, 1, 16'd1, 64'h0005_0000_0000_0000, 8'hC0));
        check_log("partial");

        // ReLU on/off, then aborts with and without a pending partial word
        ld0 = ld_cnt[0];
        start_layer(0, 1'b1);
        send(0, 16'hFFFF, 0); send(0, 16'h8000, 0); send(0, 16'h7FFF, 0); send(0, 16'h0000, 0);
        start_layer(0, 1'b0);
        send(0, 16'hFFFF, 0); send(0, 16'h8000, 0); send(0, 16'h7FFF, 0); send(0, 16'h0000, 0);
        start_layer(0, 1'b0);
        for (int v = 1; v <= 6; v++) send(0, 16'(v), 0);
        start_layer(0, 1'b0);
        for (int v = 1; v <= 16; v++) send(0, 16'(v), 0);
        wait_idle(0, 20);
        exp_q.push_back(mk(0, 0, 16'd0, 64'h0000_0000_7FFF_0000, 8'hFF));
        exp_q.push_back(mk(0, 0, 16'd0, 64'hFFFF_8000_7FFF_0000, 8'hFF));
        exp_q.push_back(mk(0, 0, 16'd0, 64'h0001_0002_0003_0004, 8'hFF));
        push_a_layer();
        check_log("relu_abort");
        check("ld_count_abort", 0, 128'(ld_cnt[0] - ld0), 128'(1));

        // Restart while in DONE: the finished layer still reports layer_done
        ld0 = ld_cnt[0];
        start_layer(0, 1'b0);
        for (int v = 1; v <= 16; v++) send(0, 16'(v), 0);
        start_layer(0, 1'b0);
        for (int v = 1; v <= 16; v++) send(0, 16'(v), 0);
        wait_idle(0, 20);
        push_a_layer();
        push_a_layer();
        check_log("done_restart");
        check("ld_count_restart", 0, 128'(ld_cnt[0] - ld0), 128'(2));

        // Stray sums: in IDLE, then coincident with a start
        sv[1] = 1'b1; si[1] = 16'h0007;
        @(negedge clk);
        sv[1] = 1'b0;
        check("err_idle", 1, 128'({o_err[1], o_busy[1]}), 128'(2'b10));
        ls[1] = 1'b1; sv[1] = 1'b1; si[1] = 16'h1234;
        @(negedge clk);
        ls[1] = 1'b0; sv[1] = 1'b0;
        check("err_start", 1, 128'({o_err[1], o_busy[1]}), 128'(2'b11));
        for (int v = 5; v <= 9; v++) send(1, 16'(v), 0);
        wait_idle(1, 20);
        exp_q.push_back(mk(1, 0, 16'd0, 64'h0005_0006_0007_0008, 8'hFF));
        exp_q.push_back(mk(1, 1, 16'd1, 64'h0009_0000_0000_0000, 8'hC0));
        check_log("err_layer");
        check("err_sticky", 1, 128'(o_err[1]), 128'(1));
        start_layer(1, 1'b0);
        check("err_clear", 1, 128'(o_err[1]), 128'(0));

        // Asynchronous reset in the middle of a plane
        start_layer(0, 1'b0);
        for (int v = 1; v <= 3; v++) send(0, 16'(v), 0);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++)
            check("async_rst", i, {o_wr_en[i], o_addr[i], o_data[i], o_be[i], o_busy[i],
                                   o_pd[i], o_ld[i], o_err[i], o_st[i]}, 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_log("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
